prt_tx_drain: RTL and testbench
===============================

Name: prt_tx_drain

Overview:
- Consumer-side initiator for the packet reference table (PRT).
- Accepts slot IDs of completed packets into a small in-order queue and drives the PRT start-read and read methods to fetch each packet byte by byte.
- Streams the bytes out on a valid/ready byte stream with a last flag, then frees the slot by driving the PRT invalidate method.
- Sits between the PRT and the egress MAC/TX path.

Parameters:
- DATA_WIDTH, 8: stream/PRT data width.
- NUM_SLOTS, 10: PRT slot count; SW = $clog2(NUM_SLOTS).
- SLOTQ_DEPTH, 4: pending slot-ID queue depth.
- OUT_DEPTH, 4: output FIFO depth; must be ≥ 4.
- START_TIMEOUT, 255: cycles to wait for PRT start-read ready before dropping the slot.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- EN_enq_slot  in  1  enqueue slot ID
- enq_slot_id  in  SW  slot to transmit
- RDY_enq_slot  out  1  slot queue not full
- prt_EN_start_reading  out  1  to PRT start-read enable
- prt_RDY_start_reading  in  1  from PRT
- prt_start_reading_slot  out  SW  slot being read
- prt_EN_read  out  1  to PRT read enable
- prt_RDY_read  in  1  from PRT
- prt_read_data  in  DATA_WIDTH+1  MSB=1 means end marker; low bits are data
- prt_EN_invalidate  out  1  to PRT invalidate enable
- prt_RDY_invalidate  in  1  from PRT
- prt_invalidate_slot  out  SW  slot to free
- tx_tdata  out  DATA_WIDTH  stream data
- tx_tvalid  out  1  stream valid
- tx_tlast  out  1  last byte of packet
- tx_tready  in  1  downstream ready
- busy  out  1  state != IDLE, or slot queue non-empty
- pkt_done  out  1  one-cycle pulse when invalidate fires
- err_timeout  out  1  one-cycle pulse when a slot is dropped

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - all outputs 0 except RDY_enq_slot=1;
  - queues empty, counters 0, state IDLE.
- Reset mid-packet: packet is abandoned and its slot is NOT invalidated.
- Method fire rule: a method fires in any cycle where its EN and RDY are both high. The block holds EN high until the method fires.
- Slot queue:
  - FIFO; RDY_enq_slot = !full.
  - Enqueue and dequeue in the same cycle are allowed.
  - Enqueue while full is ignored.
- States: IDLE, START, READ, PAUSE, INVAL.
- IDLE: if the slot queue is non-empty, pop the head into cur_slot, clear fwd_cnt and skip_idx, go to START.
- START:
  - prt_EN_start_reading=1, prt_start_reading_slot=cur_slot.
  - On fire: byte_idx←0, go to READ.
  - Timeout counter increments each START cycle. On reaching START_TIMEOUT: pulse err_timeout, discard cur_slot, go to IDLE, no invalidate.
  - Timeout counter clears on entry to START.
- READ:
  - prt_EN_read = (OUT FIFO free entries ≥ 2), combinational from the registered count.
  - A beat is accepted when prt_EN_read && prt_RDY_read.
  - Data beat (MSB=0):
    - if byte_idx < fwd_cnt, discard it (replay skip);
    - otherwise move any held byte into the FIFO with last=0, load the new byte into the hold register, and increment fwd_cnt;
    - byte_idx increments on every data beat.
  - Marker beat (MSB=1):
    - if hold is valid, push it with last=1;
    - go to INVAL.
    - Zero-length packet: nothing is pushed.
  - Any READ cycle with prt_EN_read=0 means the PRT has left its read phase: go to PAUSE.
- PAUSE: wait until FIFO count ≤ OUT_DEPTH/2, then go to START. The read replays from byte 0 and skips fwd_cnt bytes. The hold register is retained.
- INVAL:
  - prt_EN_invalidate=1, prt_invalidate_slot=cur_slot.
  - On fire: pulse pkt_done, go to IDLE.
  - No timeout in this state.
- Output FIFO:
  - entries are {last, data}; tvalid = !empty; pop on tvalid && tready.
  - At most one push per cycle; the 2-free-entry margin guarantees no overflow.
  - tdata and tlast must be stable while tvalid && !tready.
- Widths: fwd_cnt and byte_idx are 16 bits and do not wrap for packets ≤ 1518 bytes.
- Ordering: packets egress in enqueue order; bytes are never duplicated or dropped across any number of replays.
- Overlap: the next slot may start while earlier packets' bytes are still draining from the FIFO.

Test Plan:
- Slot 3 holds 0x11..0x15, tready=1, enqueue 3 → tx beats 11,12,13,14,15 with tlast only on 15; prt_EN_invalidate with slot 3 fires; pkt_done pulses once.
- Zero-length slot 2 (first read beat is marker 0x100) → no tx beats; invalidate slot 2; pkt_done pulses.
- 10-byte packet 0x00..0x09, tready=0 for 30 cycles after beat 2 → prt_EN_read drops, PAUSE, start-read is reissued; tx shows exactly 00..09 in order with one tlast.
- Enqueue slot 7 whose start-read is never ready → err_timeout after 255 START cycles; no invalidate for slot 7; the next queued slot 1 transmits normally.
- Enqueue 5 slots back-to-back while busy → RDY_enq_slot low once 4 are pending; packets egress in enqueue order.
- Assert RST for 1 cycle midway through a 20-byte packet → tx_tvalid=0 next cycle, state IDLE, no prt_EN_invalidate, RDY_enq_slot=1.

Source files
------------

// File: rtl/prt_tx_drain_if.sv
// Bundle of all non-clock signals of prt_tx_drain.
//   master : the drain block (slot enqueue target, PRT initiator, TX source)
//   slave  : the surroundings (slot producer, PRT, egress MAC)
// Groups: slot enqueue (EN/RDY/id), PRT start-read / read / invalidate
// methods, TX byte stream (tdata/tvalid/tlast/tready), status pulses.
interface prt_tx_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SW         = 4
);
    logic                  EN_enq_slot;
    logic [SW-1:0]         enq_slot_id;
    logic                  RDY_enq_slot;

    logic                  prt_EN_start_reading;
    logic                  prt_RDY_start_reading;
    logic [SW-1:0]         prt_start_reading_slot;

    logic                  prt_EN_read;
    logic                  prt_RDY_read;
    logic [DATA_WIDTH:0]   prt_read_data;

    logic                  prt_EN_invalidate;
    logic                  prt_RDY_invalidate;
    logic [SW-1:0]         prt_invalidate_slot;

    logic [DATA_WIDTH-1:0] tx_tdata;
    logic                  tx_tvalid;
    logic                  tx_tlast;
    logic                  tx_tready;

    logic                  busy;
    logic                  pkt_done;
    logic                  err_timeout;

    modport master (
        input  EN_enq_slot, enq_slot_id,
               prt_RDY_start_reading, prt_RDY_read, prt_read_data,
               prt_RDY_invalidate, tx_tready,
        output RDY_enq_slot, prt_EN_start_reading, prt_start_reading_slot,
               prt_EN_read, prt_EN_invalidate, prt_invalidate_slot,
               tx_tdata, tx_tvalid, tx_tlast, busy, pkt_done, err_timeout
    );

    modport slave (
        output EN_enq_slot, enq_slot_id,
               prt_RDY_start_reading, prt_RDY_read, prt_read_data,
               prt_RDY_invalidate, tx_tready,
        input  RDY_enq_slot, prt_EN_start_reading, prt_start_reading_slot,
               prt_EN_read, prt_EN_invalidate, prt_invalidate_slot,
               tx_tdata, tx_tvalid, tx_tlast, busy, pkt_done, err_timeout
    );
endinterface

// File: rtl/prt_tx_drain.sv
// prt_tx_drain: consumer-side PRT initiator. Queues completed slot IDs,
// reads each packet out of the PRT byte by byte, streams it on a
// valid/ready byte stream with tlast, then invalidates the slot.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : prt_tx_drain_if.master (slot enqueue, PRT start-read/read/
//               invalidate methods, TX stream, busy/pkt_done/err_timeout)
module prt_tx_drain #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_SLOTS     = 10,
    parameter int SLOTQ_DEPTH   = 4,
    parameter int OUT_DEPTH     = 4,
    parameter int START_TIMEOUT = 255
) (
    input  logic           CLK,
    input  logic           RST,
    prt_tx_drain_if.master bus
);
    localparam int SW    = $clog2(NUM_SLOTS);
    localparam int SQ_AW = (SLOTQ_DEPTH > 1) ? $clog2(SLOTQ_DEPTH) : 1;
    localparam int SQ_CW = $clog2(SLOTQ_DEPTH + 1);
    localparam int OF_AW = $clog2(OUT_DEPTH);
    localparam int OF_CW = $clog2(OUT_DEPTH + 1);
    localparam int TW    = $clog2(START_TIMEOUT + 1);
    localparam int OW    = DATA_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_READ, S_PAUSE, S_INVAL} state_t;

    // ---------------- slot queue ----------------
    logic [SW-1:0]    sq_mem_q [SLOTQ_DEPTH];
    logic [SW-1:0]    sq_mem_d [SLOTQ_DEPTH];
    logic [SQ_AW-1:0] sq_wr_q, sq_wr_d, sq_rd_q, sq_rd_d;
    logic [SQ_CW-1:0] sq_cnt_q, sq_cnt_d;
    logic             sq_full, sq_empty, sq_push, sq_pop;

    // ---------------- output FIFO ----------------
    logic [OW-1:0]    of_mem_q [OUT_DEPTH];
    logic [OW-1:0]    of_mem_d [OUT_DEPTH];
    logic [OF_AW-1:0] of_wr_q, of_wr_d, of_rd_q, of_rd_d;
    logic [OF_CW-1:0] of_cnt_q, of_cnt_d;
    logic             of_push, of_pop, of_room;
    logic [OW-1:0]    of_wdata;

    // ---------------- control ----------------
    state_t                state_q, state_d;
    logic [SW-1:0]         cur_slot_q, cur_slot_d;
    logic [15:0]           fwd_q, fwd_d;     // bytes already handed on (hold incl.)
    logic [15:0]           idx_q, idx_d;     // data-beat index in current read pass
    logic [TW-1:0]         tout_q, tout_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  en_start, en_read, en_inval, done_p, tout_p;

    assign sq_full  = (sq_cnt_q == SQ_CW'(SLOTQ_DEPTH));
    assign sq_empty = (sq_cnt_q == '0);
    assign sq_push  = bus.EN_enq_slot && !sq_full;

    // Two free entries: one for the byte pushed this cycle, one margin so a
    // beat accepted on the cycle the count is sampled can never overflow.
    assign of_room  = (of_cnt_q <= OF_CW'(OUT_DEPTH - 2));
    assign of_pop   = (of_cnt_q != '0) && bus.tx_tready;

    always_comb begin
        sq_mem_d = sq_mem_q;
        sq_wr_d  = sq_wr_q;
        sq_rd_d  = sq_rd_q;
        sq_cnt_d = sq_cnt_q;
        if (sq_push) begin
            sq_mem_d[sq_wr_q] = bus.enq_slot_id;
            sq_wr_d = (sq_wr_q == SQ_AW'(SLOTQ_DEPTH - 1)) ? '0 : sq_wr_q + 1'b1;
        end
        if (sq_pop)
            sq_rd_d = (sq_rd_q == SQ_AW'(SLOTQ_DEPTH - 1)) ? '0 : sq_rd_q + 1'b1;
        case ({sq_push, sq_pop})
            2'b10:   sq_cnt_d = sq_cnt_q + 1'b1;
            2'b01:   sq_cnt_d = sq_cnt_q - 1'b1;
            default: sq_cnt_d = sq_cnt_q;
        endcase
    end

    always_comb begin
        of_mem_d = of_mem_q;
        of_wr_d  = of_wr_q;
        of_rd_d  = of_rd_q;
        of_cnt_d = of_cnt_q;
        if (of_push) begin
            of_mem_d[of_wr_q] = of_wdata;
            of_wr_d = (of_wr_q == OF_AW'(OUT_DEPTH - 1)) ? '0 : of_wr_q + 1'b1;
        end
        if (of_pop)
            of_rd_d = (of_rd_q == OF_AW'(OUT_DEPTH - 1)) ? '0 : of_rd_q + 1'b1;
        case ({of_push, of_pop})
            2'b10:   of_cnt_d = of_cnt_q + 1'b1;
            2'b01:   of_cnt_d = of_cnt_q - 1'b1;
            default: of_cnt_d = of_cnt_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_slot_d = cur_slot_q;
        fwd_d      = fwd_q;
        idx_d      = idx_q;
        tout_d     = tout_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sq_pop     = 1'b0;
        of_push    = 1'b0;
        of_wdata   = '0;
        en_start   = 1'b0;
        en_read    = 1'b0;
        en_inval   = 1'b0;
        done_p     = 1'b0;
        tout_p     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sq_empty) begin
                    sq_pop     = 1'b1;
                    cur_slot_d = sq_mem_q[sq_rd_q];
                    fwd_d      = '0;
                    idx_d      = '0;
                    tout_d     = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                en_start = 1'b1;
                if (bus.prt_RDY_start_reading) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else if (tout_q == TW'(START_TIMEOUT - 1)) begin
                    // Slot dropped: whatever was held belongs to it.
                    tout_p     = 1'b1;
                    hold_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            S_READ: begin
                en_read = of_room;
                if (!of_room) begin
                    // Dropping EN_read ends the PRT read phase; replay later.
                    state_d = S_PAUSE;
                end else if (bus.prt_RDY_read) begin
                    if (bus.prt_read_data[DATA_WIDTH]) begin
                        if (hold_vld_q) begin
                            of_push  = 1'b1;
                            of_wdata = {1'b1, hold_q};
                        end
                        hold_vld_d = 1'b0;
                        state_d    = S_INVAL;
                    end else begin
                        if (idx_q >= fwd_q) begin
                            if (hold_vld_q) begin
                                of_push  = 1'b1;
                                of_wdata = {1'b0, hold_q};
                            end
                            hold_d     = bus.prt_read_data[DATA_WIDTH-1:0];
                            hold_vld_d = 1'b1;
                            fwd_d      = fwd_q + 1'b1;
                        end
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (of_cnt_q <= OF_CW'(OUT_DEPTH / 2)) begin
                    tout_d  = '0;
                    state_d = S_START;
                end
            end
            S_INVAL: begin
                en_inval = 1'b1;
                if (bus.prt_RDY_invalidate) begin
                    done_p  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SLOTQ_DEPTH; i++) sq_mem_q[i] <= '0;
            for (int i = 0; i < OUT_DEPTH; i++)   of_mem_q[i] <= '0;
            sq_wr_q    <= '0;
            sq_rd_q    <= '0;
            sq_cnt_q   <= '0;
            of_wr_q    <= '0;
            of_rd_q    <= '0;
            of_cnt_q   <= '0;
            state_q    <= S_IDLE;
            cur_slot_q <= '0;
            fwd_q      <= '0;
            idx_q      <= '0;
            tout_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            sq_mem_q   <= sq_mem_d;
            of_mem_q   <= of_mem_d;
            sq_wr_q    <= sq_wr_d;
            sq_rd_q    <= sq_rd_d;
            sq_cnt_q   <= sq_cnt_d;
            of_wr_q    <= of_wr_d;
            of_rd_q    <= of_rd_d;
            of_cnt_q   <= of_cnt_d;
            state_q    <= state_d;
            cur_slot_q <= cur_slot_d;
            fwd_q      <= fwd_d;
            idx_q      <= idx_d;
            tout_q     <= tout_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign bus.RDY_enq_slot           = !sq_full;
    assign bus.prt_EN_start_reading   = en_start;
    assign bus.prt_start_reading_slot = cur_slot_q;
    assign bus.prt_EN_read            = en_read;
    assign bus.prt_EN_invalidate      = en_inval;
    assign bus.prt_invalidate_slot    = cur_slot_q;
    assign bus.tx_tvalid              = (of_cnt_q != '0);
    assign bus.tx_tlast               = of_mem_q[of_rd_q][DATA_WIDTH];
    assign bus.tx_tdata               = of_mem_q[of_rd_q][DATA_WIDTH-1:0];
    assign bus.busy                   = (state_q != S_IDLE) || !sq_empty;
    assign bus.pkt_done               = done_p;
    assign bus.err_timeout            = tout_p;
endmodule

// File: tb/tb_prt_tx_drain.sv
module tb_prt_tx_drain;
    localparam int DW = 8;
    localparam int NS = 10;
    localparam int SW = $clog2(NS);
    localparam int TO = 255;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    prt_tx_drain_if #(.DATA_WIDTH(DW), .SW(SW)) bus ();

    prt_tx_drain #(
        .DATA_WIDTH(DW), .NUM_SLOTS(NS), .SLOTQ_DEPTH(4),
        .OUT_DEPTH(4), .START_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // PRT contents and per-slot "start-read never ready" flag.
    logic [DW-1:0] mem [NS][32];
    int            plen [NS];
    bit            dead [NS];

    // Reference: expected beats {last,data} and invalidates, in enqueue order.
    logic [DW:0]   exp_q [$];
    logic [SW-1:0] exp_inv [$];
    logic [DW:0]   cap [$];
    int            n_done = 0, n_to = 0, n_starts = 0;
    logic [SW-1:0] last_inv = '0;
    bit            tr_always = 1'b1, tr_force0 = 1'b0, stall_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // PRT model, downstream sink and scoreboard. Samples at negedge,
    // drives at posedge+1.
    initial begin : env
        bit            rst_s, s_fire, r_fire, inv_fire, en_rd_s, phase, prev_stall;
        logic [DW:0]   rd_s, prev_beat, e, beat;
        logic [SW-1:0] s_slot, cur;
        int            ptr, stall_cnt, start_run, pkt_beat, s;
        phase = 0; prev_stall = 0; ptr = 0; stall_cnt = 0; start_run = 0;
        pkt_beat = 0; cur = '0; prev_beat = '0;
        bus.prt_RDY_start_reading = 1'b0;
        bus.prt_RDY_read          = 1'b0;
        bus.prt_read_data         = '0;
        bus.prt_RDY_invalidate    = 1'b0;
        bus.tx_tready             = 1'b0;
        forever begin
            @(negedge CLK);
            rst_s    = RST;
            s_fire   = bus.prt_EN_start_reading && bus.prt_RDY_start_reading;
            r_fire   = bus.prt_EN_read && bus.prt_RDY_read;
            inv_fire = bus.prt_EN_invalidate && bus.prt_RDY_invalidate;
            en_rd_s  = bus.prt_EN_read;
            rd_s     = bus.prt_read_data;
            s_slot   = bus.prt_start_reading_slot;
            beat     = {bus.tx_tlast, bus.tx_tdata};
            if (rst_s) begin
                exp_q.delete();
                exp_inv.delete();
                start_run = 0; pkt_beat = 0; prev_stall = 0;
            end else begin
                if (bus.EN_enq_slot && bus.RDY_enq_slot) begin
                    s = int'(bus.enq_slot_id);
                    if (!dead[s]) begin
                        for (int i = 0; i < plen[s]; i++)
                            exp_q.push_back({(i == plen[s] - 1), mem[s][i]});
                        exp_inv.push_back(bus.enq_slot_id);
                    end
                end
                if (prev_stall) begin
                    chk("tx_hold_valid", bus.tx_tvalid, 1);
                    chk("tx_hold_stable", beat, prev_beat);
                end
                if (bus.tx_tvalid && bus.tx_tready) begin
                    cap.push_back(beat);
                    if (exp_q.size() == 0) chk("tx_extra_beat", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("tx_beat", beat, e);
                    end
                    if (stall_en && pkt_beat == 2) begin
                        stall_cnt = 30;
                        stall_en  = 0;
                    end
                    pkt_beat = bus.tx_tlast ? 0 : pkt_beat + 1;
                end
                prev_stall = bus.tx_tvalid && !bus.tx_tready;
                prev_beat  = beat;
                if (bus.pkt_done || inv_fire) chk("pkt_done_pulse", bus.pkt_done, inv_fire);
                if (inv_fire) begin
                    n_done++;
                    last_inv = bus.prt_invalidate_slot;
                    if (exp_inv.size() == 0) chk("inval_extra", exp_inv.size(), 1);
                    else chk("inval_slot", bus.prt_invalidate_slot, exp_inv.pop_front());
                end
                if (bus.prt_EN_start_reading) start_run++;
                if (bus.err_timeout) begin
                    n_to++;
                    chk("timeout_cycles", start_run, TO);
                    chk("timeout_in_start", bus.prt_EN_start_reading, 1);
                end
                if (!bus.prt_EN_start_reading || s_fire || bus.err_timeout) start_run = 0;
                if (s_fire) n_starts++;
            end
            @(posedge CLK);
            #1;
            if (rst_s) phase = 0;
            else if (s_fire) begin
                phase = 1; ptr = 0; cur = s_slot;
            end else if (phase) begin
                if (!en_rd_s) phase = 0;
                else if (r_fire) begin
                    if (rd_s[DW]) phase = 0;
                    else ptr++;
                end
            end
            if (stall_cnt > 0) stall_cnt--;
            bus.tx_tready = !tr_force0 && (stall_cnt == 0) && (tr_always || ($urandom_range(0, 3) != 0));
            bus.prt_RDY_start_reading = !dead[int'(bus.prt_start_reading_slot)] && ($urandom_range(0, 3) != 0);
            bus.prt_RDY_read = phase && ($urandom_range(0, 4) != 0);
            if (!phase) bus.prt_read_data = '0;
            else if (ptr < plen[int'(cur)]) bus.prt_read_data = {1'b0, mem[int'(cur)][ptr]};
            else bus.prt_read_data = {1'b1, {DW{1'b0}}};
            bus.prt_RDY_invalidate = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic enq(input int s);
        int t = 0;
        while (!bus.RDY_enq_slot && t < 3000) begin cyc(1); t++; end
        chk("enq_ready_wait", bus.RDY_enq_slot, 1);
        bus.EN_enq_slot = 1'b1;
        bus.enq_slot_id = SW'(s);
        cyc(1);
        bus.EN_enq_slot = 1'b0;
    endtask

    task automatic drain(input int lim);
        int t = 0;
        while ((bus.busy || bus.tx_tvalid) && t < lim) begin cyc(1); t++; end
        chk("drain_idle", bus.busy || bus.tx_tvalid, 0);
        cyc(2);
        chk("exp_beats_left", exp_q.size(), 0);
        chk("exp_inval_left", exp_inv.size(), 0);
    endtask

    initial begin : wdog
        #3000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, s0, t0, t;
        bus.EN_enq_slot = 1'b0;
        bus.enq_slot_id = '0;
        for (int s = 0; s < NS; s++) begin
            plen[s] = 0; dead[s] = 0;
            for (int i = 0; i < 32; i++) mem[s][i] = '0;
        end
        RST = 1'b1;
        cyc(3);
        chk("rst_rdy_enq", bus.RDY_enq_slot, 1);
        chk("rst_tvalid", bus.tx_tvalid, 0);
        chk("rst_tlast_tdata", {bus.tx_tlast, bus.tx_tdata}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_en_methods", {bus.prt_EN_start_reading, bus.prt_EN_read, bus.prt_EN_invalidate}, 0);
        chk("rst_pulses", {bus.pkt_done, bus.err_timeout}, 0);
        RST = 1'b0;
        cyc(2);

        // 5-byte packet, always ready
        plen[3] = 5;
        for (int i = 0; i < 5; i++) mem[3][i] = 8'h11 + DW'(i);
        tr_always = 1; cap.delete(); d0 = n_done;
        enq(3);
        drain(500);
        chk("t1_len", cap.size(), 5);
        for (int i = 0; i < cap.size() && i < 5; i++)
            chk("t1_beat", cap[i], {(i == 4), 8'h11 + DW'(i)});
        chk("t1_done", n_done - d0, 1);
        chk("t1_inv_slot", last_inv, 3);

        // zero-length packet
        plen[2] = 0; cap.delete(); d0 = n_done;
        enq(2);
        drain(500);
        chk("t2_no_beats", cap.size(), 0);
        chk("t2_done", n_done - d0, 1);
        chk("t2_inv_slot", last_inv, 2);

        // 10-byte packet with a 30-cycle sink stall -> pause and replay
        plen[4] = 10;
        for (int i = 0; i < 10; i++) mem[4][i] = DW'(i);
        cap.delete(); s0 = n_starts; stall_en = 1;
        enq(4);
        drain(2000);
        chk("t3_len", cap.size(), 10);
        for (int i = 0; i < cap.size() && i < 10; i++)
            chk("t3_beat", cap[i], {(i == 9), DW'(i)});
        chk("t3_replayed", (n_starts - s0) > 1, 1);

        // start-read never ready on slot 7, slot 1 follows
        dead[7] = 1; plen[1] = 6;
        for (int i = 0; i < 6; i++) mem[1][i] = DW'($urandom);
        cap.delete(); t0 = n_to;
        enq(7);
        enq(1);
        drain(2000);
        chk("t4_timeouts", n_to - t0, 1);
        chk("t4_inv_slot", last_inv, 1);
        chk("t4_len", cap.size(), 6);
        dead[7] = 0;

        // queue fill: one long packet held, four more pending
        plen[5] = 24; plen[6] = 3; plen[8] = 1; plen[9] = 7; plen[0] = 2;
        for (int i = 0; i < 24; i++) begin
            mem[5][i] = DW'($urandom); mem[6][i] = DW'($urandom);
            mem[8][i] = DW'($urandom); mem[9][i] = DW'($urandom);
            mem[0][i] = DW'($urandom);
        end
        tr_always = 0; tr_force0 = 1; cap.delete();
        enq(5);
        cyc(4);
        enq(6); enq(8); enq(9); enq(0);
        chk("t5_full_rdy", bus.RDY_enq_slot, 0);
        chk("t5_busy", bus.busy, 1);
        tr_force0 = 0;
        enq(3);
        drain(4000);
        chk("t5_beats", cap.size(), 24 + 3 + 1 + 7 + 2 + 5);
        chk("t5_last_inv", last_inv, 3);

        // reset in the middle of a 20-byte packet
        plen[9] = 20; cap.delete(); d0 = n_done;
        enq(9);
        t = 0;
        while (cap.size() < 8 && t < 1000) begin cyc(1); t++; end
        chk("t6_progress", cap.size() >= 8, 1);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("t6_tvalid", bus.tx_tvalid, 0);
        chk("t6_no_inval", bus.prt_EN_invalidate, 0);
        chk("t6_rdy_enq", bus.RDY_enq_slot, 1);
        chk("t6_idle", {bus.busy, bus.prt_EN_start_reading, bus.prt_EN_read}, 0);
        t = cap.size();
        cyc(30);
        chk("t6_quiet", cap.size(), t);
        chk("t6_done_cnt", n_done, d0);

        // randomized traffic
        for (int s = 0; s < NS; s++) begin
            plen[s] = $urandom_range(0, 24);
            for (int i = 0; i < 32; i++) mem[s][i] = DW'($urandom);
        end
        d0 = n_done; tr_always = 0;
        for (int k = 0; k < 40; k++) begin
            enq($urandom_range(0, NS - 1));
            if ($urandom_range(0, 1) != 0) cyc($urandom_range(1, 6));
        end
        drain(20000);
        chk("rand_done", n_done - d0, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
